// File: rtl/qbus_dma_master.sv
// qbus_dma_master
// Qbus bus-master engine. It executes one single-word DATI, DATO or DATOB
// cycle per command. It runs the DMA arbitration (BDMR/BDMGI/BSACK),
// passes through grants it did not request, phases address and data on BDAL,
// waits for BRPLY, and aborts a cycle that gets no reply.
//
// Ports
//   clock, reset        system clock; synchronous active-high reset
//   start               one-cycle command strobe, ignored while busy
//   cmd_write/cmd_byte  1 = DATO (cmd_byte selects DATOB), 0 = DATI
//   cmd_addr            22-bit Qbus byte address
//   cmd_wdata           write data, already lane-positioned
//   busy, done, error   status; error is valid with done (1 = no-reply timeout)
//   rdata               last captured read word
//   BDALf_IN            inverted bus receivers (true value = ~BDALf_IN)
//   BDALf_OUT/BDALf_OE  true-polarity driver data and per-bit enables
//   Outbound            BDAL gate-driver enable
//   BSYNCf/BRPLYf/BDMGIf  receivers, low = asserted, double-flop synchronized
//   B*g                 MOSFET gates, high = assert line
//   fsm_state           current state encoding, for observation
//
// Handshake: start is accepted only in IDLE (busy low). It is a single-cycle
// request and has no ready signal. done pulses for exactly one cycle per
// accepted command, except when reset aborts the cycle.
module qbus_dma_master #(
  parameter int T_ASETUP  = 16,
  parameter int T_DSAMPLE = 20,
  parameter int T_WSETUP  = 10,
  parameter int TIMEOUT   = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_write,
  input  logic        cmd_byte,
  input  logic [21:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] rdata,
  input  logic [21:0] BDALf_IN,
  output logic [21:0] BDALf_OUT,
  output logic [21:0] BDALf_OE,
  output logic        Outbound,
  input  logic        BSYNCf,
  input  logic        BRPLYf,
  input  logic        BDMGIf,
  output logic        BSYNCg,
  output logic        BDINg,
  output logic        BDOUTg,
  output logic        BWTBTg,
  output logic        BBS7g,
  output logic        BDMRg,
  output logic        BSACKg,
  output logic        BDMGOg,
  output logic [3:0]  fsm_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_GRANT, S_ADDR, S_DSETUP,
    S_WAIT_RPLY, S_RD_SAMPLE, S_WAIT_NRPLY, S_FINISH
  } state_t;

  localparam int CW = 16;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          latch_cmd, set_err, capture;

  logic          wr_r, byte_r;
  logic [21:0]   addr_r;
  logic [15:0]   wdata_r;

  // Receivers idle high (negated), so the synchronizers reset to 1.
  logic [1:0]    sync_ff, rply_ff, dmgi_ff;
  logic          bsync_s, brply_s, dmgi_s;

  // Only the low 16 data lines carry read data.
  logic          unused_bdal;
  assign unused_bdal = ^BDALf_IN[21:16];

  assign bsync_s   = ~sync_ff[1];
  assign brply_s   = ~rply_ff[1];
  assign dmgi_s    = ~dmgi_ff[1];
  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_ff <= 2'b11;
      rply_ff <= 2'b11;
      dmgi_ff <= 2'b11;
    end else begin
      sync_ff <= {sync_ff[0], BSYNCf};
      rply_ff <= {rply_ff[0], BRPLYf};
      dmgi_ff <= {dmgi_ff[0], BDMGIf};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wr_r    <= 1'b0;
      byte_r  <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      error   <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch_cmd) begin
        wr_r    <= cmd_write;
        byte_r  <= cmd_write & cmd_byte;
        addr_r  <= cmd_addr;
        wdata_r <= cmd_wdata;
        error   <= 1'b0;
      end
      if (set_err) error <= 1'b1;
      if (capture) rdata <= ~BDALf_IN[15:0];
    end
  end

  // Next state. cnt times the address setup, the write setup, the reply
  // timeout and the read-sample delay. It restarts at 0 on each phase entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    latch_cmd = 1'b0;
    set_err   = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          latch_cmd = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        cnt_nxt = '0;
        if (dmgi_s) state_nxt = S_GRANT;
      end
      S_GRANT: begin
        cnt_nxt = '0;
        // The previous master must release SYNC and RPLY before we take the bus.
        if (!bsync_s && !brply_s) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (cnt == CW'(T_ASETUP - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_DSETUP;
        end
      end
      S_DSETUP: begin
        // A read needs only one turnaround cycle with the drivers off.
        if (!wr_r || cnt == CW'(T_WSETUP - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT_RPLY;
        end
      end
      S_WAIT_RPLY: begin
        // If the reply and the timeout arrive in the same cycle, the reply wins.
        if (brply_s) begin
          cnt_nxt   = '0;
          state_nxt = wr_r ? S_WAIT_NRPLY : S_RD_SAMPLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          set_err   = 1'b1;
          state_nxt = S_FINISH;
        end
      end
      S_RD_SAMPLE: begin
        if (cnt == CW'(T_DSAMPLE - 1)) begin
          capture   = 1'b1;
          state_nxt = S_WAIT_NRPLY;
        end
      end
      S_WAIT_NRPLY: begin
        if (!brply_s) state_nxt = S_FINISH;
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Line outputs are decoded from the registered state.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = 1'b0;
    BDALf_OUT = '0;
    BDALf_OE  = '0;
    Outbound  = 1'b0;
    BSYNCg    = 1'b0;
    BDINg     = 1'b0;
    BDOUTg    = 1'b0;
    BWTBTg    = 1'b0;
    BBS7g     = 1'b0;
    BDMRg     = 1'b0;
    BSACKg    = 1'b0;
    BDMGOg    = 1'b0;
    case (state)
      S_IDLE:  BDMGOg = dmgi_s;
      S_REQ:   BDMRg  = 1'b1;
      S_GRANT: BDMRg  = 1'b1;
      S_ADDR: begin
        BSACKg    = 1'b1;
        Outbound  = 1'b1;
        BDALf_OE  = '1;
        BDALf_OUT = addr_r;
        BBS7g     = &addr_r[21:13];
        BWTBTg    = wr_r;
      end
      S_DSETUP, S_WAIT_RPLY, S_WAIT_NRPLY: begin
        BSYNCg = 1'b1;
        BSACKg = 1'b1;
        // Write data is held on BDAL until the slave negates RPLY.
        if (wr_r) begin
          Outbound  = 1'b1;
          BDALf_OE  = '1;
          BDALf_OUT = {6'b0, wdata_r};
          BWTBTg    = byte_r;
        end
        if (state == S_WAIT_RPLY) begin
          BDOUTg = wr_r;
          BDINg  = ~wr_r;
        end
      end
      S_RD_SAMPLE: begin
        BSYNCg = 1'b1;
        BSACKg = 1'b1;
        BDINg  = 1'b1;
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qbus_dma_master.sv
module tb_qbus_dma_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        cmd_write, cmd_byte;
  logic [21:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        busy, done, error;
  logic [15:0] rdata;
  logic [21:0] BDALf_IN, BDALf_OUT, BDALf_OE;
  logic        Outbound;
  logic        BSYNCf, BRPLYf, BDMGIf;
  logic        BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg;
  logic [3:0]  fsm_state;

  logic [21:0] slave_bdal;
  logic [15:0] model_rdata;
  logic [16:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          mutex_viol = 0;
  int          done_cnt = 0;

  // The receivers see the inverse of whatever is on the bus.
  assign BDALf_IN = BDALf_OE[0] ? ~BDALf_OUT : slave_bdal;

  qbus_dma_master dut (
    .clock(clock), .reset(reset), .start(start),
    .cmd_write(cmd_write), .cmd_byte(cmd_byte), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .busy(busy), .done(done), .error(error), .rdata(rdata),
    .BDALf_IN(BDALf_IN), .BDALf_OUT(BDALf_OUT), .BDALf_OE(BDALf_OE), .Outbound(Outbound),
    .BSYNCf(BSYNCf), .BRPLYf(BRPLYf), .BDMGIf(BDMGIf),
    .BSYNCg(BSYNCg), .BDINg(BDINg), .BDOUTg(BDOUTg), .BWTBTg(BWTBTg), .BBS7g(BBS7g),
    .BDMRg(BDMRg), .BSACKg(BSACKg), .BDMGOg(BDMGOg), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clock) begin
    if (BDINg && BDOUTg) mutex_viol++;
    if (Outbound && BDINg) mutex_viol++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return BDMRg;
      1:       return BSACKg;
      2:       return BSYNCg;
      3:       return BDINg;
      4:       return BDOUTg;
      default: return done;
    endcase
  endfunction

  // Counts negedges until the selected output reaches level, bounded by limit.
  task automatic wait_sig(input string tag, input int which, input logic level,
                          input int limit, output int n);
    n = 0;
    while (sig(which) !== level && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (n >= limit) check({tag, "_bound"}, {31'b0, sig(which)}, {31'b0, level});
  endtask

  // driver: one full bus transaction with the bench acting as arbiter and slave.
  // rply_dly < 0 means the slave never replies.
  task automatic run_cmd(input logic wr, input logic by, input logic [21:0] addr,
                         input logic [15:0] wd, input logic [15:0] rword,
                         input int rply_dly, input logic exp_bbs7, input logic hold_bus);
    int n;
    logic exp_err;
    logic [16:0] exp;
    exp_err = (rply_dly < 0);
    if (!wr && !exp_err) model_rdata = rword;
    exp_q.push_back({exp_err, model_rdata});

    cmd_write = wr; cmd_byte = by; cmd_addr = addr; cmd_wdata = wd; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy", {31'b0, busy}, 1);
    wait_sig("req", 0, 1'b1, 10, n);
    if (hold_bus) begin
      BSYNCf = 1'b0;
      BRPLYf = 1'b0;
    end
    BDMGIf = 1'b0;
    if (hold_bus) begin
      repeat (20) @(negedge clock);
      check("sack_sync_held", {31'b0, BSACKg}, 0);
      check("dmgo_busy", {31'b0, BDMGOg}, 0);
      BSYNCf = 1'b1;
      repeat (10) @(negedge clock);
      check("sack_rply_held", {31'b0, BSACKg}, 0);
      BRPLYf = 1'b1;
    end
    wait_sig("sack", 1, 1'b1, 20, n);
    check("bdmr_drop", {31'b0, BDMRg}, 0);
    BDMGIf = 1'b1;
    check("addr", {10'b0, BDALf_OUT}, {10'b0, addr});
    check("bbs7_addr", {31'b0, BBS7g}, {31'b0, exp_bbs7});
    check("wtbt_addr", {31'b0, BWTBTg}, {31'b0, wr});
    check("outbound_addr", {31'b0, Outbound}, 1);
    wait_sig("sync", 2, 1'b1, 100, n);
    check("t_asetup", n, 16);
    if (wr) begin
      check("wdata", {10'b0, BDALf_OUT}, {16'b0, wd});
      check("wtbt_data", {31'b0, BWTBTg}, {31'b0, by});
      check("bbs7_data", {31'b0, BBS7g}, 0);
      wait_sig("dout", 4, 1'b1, 100, n);
      check("t_wsetup", n, 10);
    end else begin
      check("oe_read", {10'b0, BDALf_OE}, 0);
      wait_sig("din", 3, 1'b1, 10, n);
      check("t_din", n, 1);
    end
    if (rply_dly < 0) begin
      wait_sig("timeout", 3, 1'b0, 2000, n);
      check("t_timeout", n, 1000);
    end else begin
      repeat (rply_dly) @(negedge clock);
      if (!wr) slave_bdal = {6'h3F, ~rword};
      BRPLYf = 1'b0;
      if (wr) begin
        wait_sig("dout_neg", 4, 1'b0, 10, n);
        repeat (5) @(negedge clock);
        check("wdata_hold", {16'b0, BDALf_OUT[15:0]}, {16'b0, wd});
        check("outbound_hold", {31'b0, Outbound}, 1);
      end else begin
        wait_sig("din_neg", 3, 1'b0, 100, n);
      end
      BRPLYf = 1'b1;
      slave_bdal = '1;
    end
    wait_sig("done", 5, 1'b1, 20, n);
    exp = exp_q.pop_front();
    check("err_rdata", {15'b0, error, rdata}, {15'b0, exp});
    check("released", {26'b0, BSYNCg, BSACKg, BDINg, BDOUTg, Outbound, |BDALf_OE}, 0);
    @(negedge clock);
    check("done_pulse", {31'b0, done}, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; cmd_write = 1'b0; cmd_byte = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    BSYNCf = 1'b1; BRPLYf = 1'b1; BDMGIf = 1'b1;
    slave_bdal = '1; model_rdata = '0;
    repeat (3) @(negedge clock);
    check("reset_lines", {22'b0, BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg,
                          Outbound, |BDALf_OE}, 0);
    check("reset_status", {13'b0, busy, done, error, rdata}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // DATI at 0o001000
    run_cmd(1'b0, 1'b0, 22'o001000, 16'h0, 16'o123456, 30, 1'b0, 1'b0);
    // DATO into the I/O page
    run_cmd(1'b1, 1'b0, 22'o17772152, 16'hBEEF, 16'h0, 12, 1'b1, 1'b0);
    // DATOB to an even address
    run_cmd(1'b1, 1'b1, 22'o000400, 16'h00A5, 16'h0, 5, 1'b0, 1'b0);
    // no reply, then a clean read clears error
    run_cmd(1'b0, 1'b0, 22'o004000, 16'h0, 16'h0, -1, 1'b0, 1'b0);
    run_cmd(1'b0, 1'b0, 22'o004002, 16'h0, 16'h1234, $urandom_range(1, 40), 1'b0, 1'b0);

    // unrequested grant passes downstream
    BDMGIf = 1'b0;
    repeat (2) @(negedge clock);
    check("dmgo_pass", {31'b0, BDMGOg}, 1);
    BDMGIf = 1'b1;
    repeat (3) @(negedge clock);
    check("dmgo_release", {31'b0, BDMGOg}, 0);

    // grant arriving while another master holds SYNC and RPLY
    run_cmd(1'b1, 1'b0, 22'o010000, 16'h5A5A, 16'h0, 3, 1'b0, 1'b1);

    // reset in WAIT_RPLY, with an extra start while busy
    cmd_write = 1'b0; cmd_byte = 1'b0; cmd_addr = 22'o002000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_sig("t6_req", 0, 1'b1, 10, n);
    BDMGIf = 1'b0;
    wait_sig("t6_sack", 1, 1'b1, 20, n);
    BDMGIf = 1'b1;
    wait_sig("t6_din", 3, 1'b1, 100, n);
    cmd_addr = 22'o003777; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("t6_busy", {31'b0, busy}, 1);
    check("t6_still_din", {31'b0, BDINg}, 1);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    model_rdata = '0;
    check("t6_lines", {22'b0, BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg,
                       Outbound, |BDALf_OE}, 0);
    check("t6_status", {13'b0, busy, done, error, rdata}, {16'b0, model_rdata});
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("t6_idle", {30'b0, busy, BDMRg}, 0);

    check("mutex", mutex_viol, 0);
    check("done_count", done_cnt, 6);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qbus_dma_master.md
Name: qbus_dma_master

Overview:
- Qbus bus-master engine: executes single-word DATI/DATO cycles into PDP-11 memory on command from the H723 (via the FMC register decoder).
- Sits beside the IR/SA slave on the same BDAL gate drivers and transceivers. Moves MSCP command/response ring entries and descriptors.
- Handles DMA arbitration (BDMR/BDMGI/BSACK), grant pass-through, address/data phasing, reply wait and no-reply timeout.

Parameters:
- T_ASETUP, 16: clock cycles BDAL address is driven before BSYNCg asserts (≥150 ns at 100 MHz).
- T_DSAMPLE, 20: cycles from synchronized BRPLY assertion to read-data capture.
- T_WSETUP, 10: cycles write data/BWTBT are held before BDOUTg asserts.
- TIMEOUT, 1000: cycles allowed from BDIN/BDOUT assertion to BRPLY before abort (10 µs).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command strobe; ignored while busy
- cmd_write  in  1  1 = DATO, 0 = DATI
- cmd_byte  in  1  byte write (DATOB); ignored for reads
- cmd_addr  in  22  Qbus byte address
- cmd_wdata  in  16  write data, already lane-positioned by caller
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done: 1 = timeout
- rdata  out  16  captured read data, held until next read completes
- BDALf_IN  in  22  bus receivers, inverted (true value = ~BDALf_IN)
- BDALf_OUT  out  22  true-polarity data to FPGA drivers
- BDALf_OE  out  22  FPGA driver enables
- Outbound  out  1  BDAL gate-driver enable
- BSYNCf, BRPLYf, BDMGIf  in  1 each  bus receivers, low = asserted; double-flop synchronized internally
- BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, BDMRg, BSACKg, BDMGOg  out  1 each  MOSFET gates, high = assert line

Behaviour:
- Reset (and on every clock while reset is high): state IDLE; all g outputs 0; Outbound 0; BDALf_OE 0; busy/done/error 0; rdata 0.
- Reset mid-cycle: all lines negate the next cycle. No done pulse.
- IDLE: start latches cmd_* into holding registers; next state REQ; busy goes high. start while busy is dropped.
- REQ: BDMRg=1. Wait for synchronized BDMGI asserted, then go to GRANT.
- GRANT: wait for BSYNC and BRPLY both negated (synchronized). Then BSACKg=1 and BDMRg=0 in the same cycle; go to ADDR.
- BDMGOg: equals synchronized DMGI whenever state is IDLE; 0 in all other states. A grant we did not request is passed downstream.
- ADDR: Outbound=1, OE=all ones, BDALf_OUT=address. BBS7g=1 iff addr[21:13] all ones. BWTBTg=cmd_write. Hold T_ASETUP cycles; then BSYNCg=1 and go to DATA_SETUP.
- BSYNCg stays 1 and BSACKg stays 1 until FINISH.
- DATA_SETUP (write): BDALf_OUT[15:0]=wdata, bits [21:16]=0. BWTBTg=cmd_byte. BBS7g=0. Hold T_WSETUP cycles, then BDOUTg=1.
- DATA_SETUP (read): drivers off (OE=0, Outbound=0), BBS7g=0, BWTBTg=0. BDINg=1 the following cycle.
- WAIT_RPLY: timeout counter starts at 0 on strobe assertion.
  - BRPLY asserted, read: wait T_DSAMPLE cycles, rdata <= ~BDALf_IN[15:0], BDINg=0.
  - BRPLY asserted, write: BDOUTg=0 immediately.
  - Go to WAIT_NRPLY.
  - Counter reaches TIMEOUT: negate the strobe, set error, go to FINISH.
- WAIT_NRPLY: wait for synchronized BRPLY negated. On write, data stays driven until then. No timeout in this state.
- FINISH: BSYNCg, BSACKg, BWTBTg, Outbound, OE all 0. done=1 for one cycle. error valid the same cycle. Return to IDLE.
- Mutual exclusion: BDINg and BDOUTg are never 1 together. Outbound is never 1 while BDINg=1.
- error clears on the next start.

Test Plan:
1. DATI at 0o001000: bench grants DMGI, replies 30 cycles after BDIN with bus word ~16'o123456 → address phase 16 cycles before BSYNC, BBS7g=0; rdata=16'o123456; done=1, error=0.
2. DATO word 16'hBEEF at 0o17772152 → BBS7g=1 during address; BWTBTg=1 in address phase, 0 in data phase; BDOUTg after 10 cycles; data held until BRPLY negates.
3. DATOB 16'h00A5 to an even address → BWTBTg=1 in both phases; done with error=0.
4. No BRPLY → BDINg negated after exactly 1000 cycles; done=1, error=1; lines released; a following start succeeds.
5. DMGI asserted with no pending request → BDMGOg follows it within 2 clocks. Grant arriving while the bus is held (BSYNC asserted) → BSACK waits until BSYNC and BRPLY negate.
6. Reset in WAIT_RPLY; start pulsed while busy → all g outputs 0 the next cycle, no done; the extra start is ignored.
